ps2_keyboard_receiver: RTL and testbench
========================================

// Module: ps2_keyboard_receiver
// PURPOSE
//  Parametrised PS/2 keyboard front end. Everything runs on the system Clock; PS2_CLK is treated as data, not as a clock.
//  Samples and filters the PS/2 lines, checks each 11-bit frame, and folds E0/F0 prefixes into a decoded key event.
//  Key events go into a FIFO read with a valid/ready handshake. Feeds the game/VGA control logic.
// PARAMETERS
//  SYNC_STAGES     2      flip-flop stages on iPS2_CLK and iPS2_DATA (>=2)
//  FILTER_LEN      8      consecutive equal samples needed before filtered PS2_CLK changes
//  TIMEOUT_CYCLES  50000  Clock cycles with no falling edge mid-frame before the frame is aborted
//  FIFO_DEPTH      4      event entries; power of 2, >=2
//  CNT_W           3      width of oCount, equal to log2(FIFO_DEPTH)+1
// PORTS
//  Clock         in   1      system clock, rising edge
//  Reset         in   1      synchronous, active-low
//  iPS2_CLK      in   1      raw PS/2 clock pin
//  iPS2_DATA     in   1      raw PS/2 data pin
//  oCode         out  8      scan code at FIFO head
//  oBreak        out  1      head event is a key release (F0 prefix)
//  oExtended     out  1      head event carries the E0 prefix
//  oValid        out  1      FIFO not empty
//  iReady        in   1      consumer accepts the head; pop when oValid && iReady
//  oCount        out  CNT_W  FIFO occupancy
//  oParityError  out  1      1-cycle pulse: frame discarded on odd-parity failure
//  oFrameError   out  1      1-cycle pulse: stop bit = 0, or timeout
//  oOverflow     out  1      1-cycle pulse: complete event dropped because FIFO full
// BEHAVIOUR
//  Reset (Reset==0 at a Clock edge):
//   - all outputs 0; FSM IDLE; FIFO empty; prefix flags clear.
//   - filtered clock is forced to 1. Applies mid-frame too: the partial frame is lost.
//  Input path:
//   - SYNC_STAGES synchroniser, then a FILTER_LEN sample filter on the clock line.
//   - fall = 1-cycle strobe on a filtered 1->0 transition; data is sampled (synchronised) on that cycle.
//  FSM (advances only on fall, apart from timeout):
//   - IDLE: data==0 -> DATA, bit counter = 0; data==1 -> stay in IDLE (spurious edge).
//   - DATA: shift in LSB first; after the 8th bit -> PARITY.
//   - PARITY: store the parity bit -> STOP.
//   - STOP -> IDLE in every case.
//     - Stop bit 0: pulse oFrameError.
//     - Else if ^data ^ parity == 0: pulse oParityError.
//     - Else the byte is good.
//   - Timeout: outside IDLE, TIMEOUT_CYCLES cycles without fall -> IDLE and pulse oFrameError.
//     The timeout counter reloads on every fall.
//   - A bad frame never changes the prefix flags or the FIFO.
//  Decoder (on a good byte):
//   - E0 -> ext=1.
//   - F0 -> brk=1.
//   - Any other byte -> push {ext,brk,byte}, then clear both flags.
//   - Flags clear on reset only; no flag timeout.
//  FIFO (first-word fall-through):
//   - Head is always visible on oCode/oBreak/oExtended.
//   - Latency: a good stop-bit fall in cycle N writes the FIFO at edge N+1; oValid=1 from cycle N+2 when the FIFO was empty.
//   - Push while full with no pop: entry dropped, oOverflow pulses, contents unchanged.
//   - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
//   - Push and pop in the same cycle while empty: push only (the pop is not valid).
//   - Pointers wrap modulo FIFO_DEPTH; oCount ranges 0..FIFO_DEPTH.
//   - Head outputs are don't-care while oValid==0.
// STRUCTURE
//  Shared include ps2_defs.vh:
//   - `PS2_EXT 8'hE0, `PS2_BREAK 8'hF0.
//   - FSM state encodings: IDLE, DATA, PARITY, STOP (2-bit).
//  One sub-module: sync_fifo #(WIDTH=10, DEPTH)
//   - Clock, Reset, push, pop, din, dout, full, empty, count.
//   - Same reset rules as above.
//  Filter, FSM and decoder live in this module.
// TESTING  (bench drives PS/2 bit period = 40 Clock cycles, FILTER_LEN=4, TIMEOUT_CYCLES=200)
//  1 Frame 0x1C, parity 0, stop 1, iReady=0
//    -> oValid high 2 cycles after the stop fall; oCode=1C, oBreak=0, oExtended=0, oCount=1.
//  2 Frames F0,1C then E0,F0,6B, iReady=1
//    -> two pops: {1C,brk=1,ext=0} then {6B,brk=1,ext=1}; no prefix byte ever appears in the FIFO.
//  3 Frame 0x1C with parity=1, then good 0x1C
//    -> one oParityError pulse, oCount stays 0; next event is 1C with brk=0.
//  4 FIFO_DEPTH=4, iReady=0, codes 15,1D,24,2D,2C
//    -> oCount=4, oOverflow pulses on the 5th; reads give 15,1D,24,2D.
//  5 Start + 3 data bits, then clock idle
//    -> oFrameError 200 cycles after the last fall, FSM IDLE; a following 0x29 is received intact.
//  6 Reset=0 for 1 cycle mid-frame with 2 entries queued
//    -> all outputs 0, oCount=0; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_receiver_pkg.sv
// rtl/ps2_keyboard_receiver_pkg.sv - shared PS/2 prefix codes, FSM states and key event layout
package ps2_keyboard_receiver_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// rtl/ps2_keyboard_receiver.sv - PS/2 line filter, frame FSM, E0/F0 decoder and event FIFO
module ps2_keyboard_receiver
    import ps2_keyboard_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CNT_W          = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPS2_CLK,
    input  logic             iPS2_DATA,
    output logic [7:0]       oCode,
    output logic             oBreak,
    output logic             oExtended,
    output logic             oValid,
    input  logic             iReady,
    output logic [CNT_W-1:0] oCount,
    output logic             oParityError,
    output logic             oFrameError,
    output logic             oOverflow
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], iPS2_CLK};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], iPS2_DATA};
        end
    end

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];

    logic             filt_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             flip;
    logic             fall;

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign flip = (ps2_clk_s != filt_q) && (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
    assign fall = flip && filt_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else if (ps2_clk_s == filt_q) begin
            flt_cnt_q <= '0;
        end else if (flip) begin
            filt_q    <= ps2_clk_s;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    ps2_state_e       state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic             ext_q;
    logic             brk_q;
    logic             push_q;
    key_event_t       ev_q;
    logic             par_err_q;
    logic             frm_err_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            push_q    <= 1'b0;
            ev_q      <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!ps2_data_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {ps2_data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= ps2_data_s;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!ps2_data_s) begin
                            frm_err_q <= 1'b1;
                        end else if ((^shift_q ^ parity_q) == 1'b0) begin
                            par_err_q <= 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_BREAK) begin
                            brk_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                            ev_q   <= '{ext: ext_q, brk: brk_q, code: shift_q};
                            ext_q  <= 1'b0;
                            brk_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q   <= ST_IDLE;
                    frm_err_q <= 1'b1;
                    tmo_q     <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    key_event_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf_q;

    assign pop = iReady && !fifo_empty;

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push_q),
        .pop   (pop),
        .din   (ev_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= push_q && fifo_full && !pop;
        end
    end

    // Head is masked while empty so the outputs read 0 straight after reset.
    assign oCode        = fifo_empty ? 8'h00 : head.code;
    assign oBreak       = !fifo_empty && head.brk;
    assign oExtended    = !fifo_empty && head.ext;
    assign oValid       = !fifo_empty;
    assign oCount       = fifo_count;
    assign oParityError = par_err_q;
    assign oFrameError  = frm_err_q;
    assign oOverflow    = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb/tb_ps2_keyboard_receiver.sv - directed bench for the PS/2 keyboard receiver
module tb_ps2_keyboard_receiver;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iPS2_CLK = 1'b1;
    logic       iPS2_DATA = 1'b1;
    logic       iReady = 1'b0;
    logic [7:0] oCode;
    logic       oBreak;
    logic       oExtended;
    logic       oValid;
    logic [2:0] oCount;
    logic       oParityError;
    logic       oFrameError;
    logic       oOverflow;

    int n_checks = 0;
    int n_errors = 0;
    int par_cnt  = 0;
    int frm_cnt  = 0;
    int ovf_cnt  = 0;
    logic [9:0] pop_log [$];

    ps2_keyboard_receiver #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (200),
        .FIFO_DEPTH     (4),
        .CNT_W          (3)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iPS2_CLK     (iPS2_CLK),
        .iPS2_DATA    (iPS2_DATA),
        .oCode        (oCode),
        .oBreak       (oBreak),
        .oExtended    (oExtended),
        .oValid       (oValid),
        .iReady       (iReady),
        .oCount       (oCount),
        .oParityError (oParityError),
        .oFrameError  (oFrameError),
        .oOverflow    (oOverflow)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        #1;
        if (oParityError) par_cnt++;
        if (oFrameError)  frm_cnt++;
        if (oOverflow)    ovf_cnt++;
        if (oValid && iReady) pop_log.push_back({oExtended, oBreak, oCode});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par, input logic stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nfalls);
        for (int i = 0; i < nfalls; i++) begin
            wait_cyc(10);
            iPS2_DATA = frame[i];
            wait_cyc(10);
            iPS2_CLK = 1'b0;
            wait_cyc(20);
            iPS2_CLK = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk(b, 1'b0, 1'b1), 11);
        wait_cyc(40);
    endtask

    task automatic pop_one();
        iReady = 1'b1;
        wait_cyc(1);
        iReady = 1'b0;
        wait_cyc(1);
    endtask

    logic [7:0] t4_codes [5];

    initial begin
        t4_codes[0] = 8'h15; t4_codes[1] = 8'h1D; t4_codes[2] = 8'h24;
        t4_codes[3] = 8'h2D; t4_codes[4] = 8'h2C;

        wait_cyc(5);
        check("reset_valid", oValid, 0);
        check("reset_count", oCount, 0);
        check("reset_code", oCode, 0);
        check("reset_errs", {oParityError, oFrameError, oOverflow}, 0);
        Reset = 1'b1;
        wait_cyc(20);

        // 1: single frame, latency and head contents
        send_bits(mk(8'h1C, 1'b0, 1'b1), 10);
        wait_cyc(10);
        iPS2_DATA = 1'b1;
        wait_cyc(10);
        iPS2_CLK = 1'b0;
        wait_cyc(6);
        check("t1_valid_early", oValid, 0);
        wait_cyc(1);
        check("t1_valid_on_time", oValid, 1);
        wait_cyc(13);
        iPS2_CLK = 1'b1;
        wait_cyc(40);
        check("t1_code", oCode, 8'h1C);
        check("t1_brk_ext", {oBreak, oExtended}, 0);
        check("t1_count", oCount, 1);
        pop_one();
        check("t1_drained", oCount, 0);

        // 2: prefixes fold into events
        pop_log.delete();
        iReady = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        iReady = 1'b0;
        wait_cyc(2);
        check("t2_pops", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            check("t2_ev0", pop_log[0], {1'b0, 1'b1, 8'h1C});
            check("t2_ev1", pop_log[1], {1'b1, 1'b1, 8'h6B});
        end
        check("t2_count", oCount, 0);

        // 3: parity error leaves FIFO and flags alone
        par_cnt = 0;
        send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
        wait_cyc(40);
        check("t3_par_pulses", par_cnt, 1);
        check("t3_count_bad", oCount, 0);
        send_byte(8'h1C);
        check("t3_count_good", oCount, 1);
        check("t3_code", oCode, 8'h1C);
        check("t3_brk", oBreak, 0);
        check("t3_par_total", par_cnt, 1);
        pop_one();

        // 4: fill to depth, overflow on the fifth
        ovf_cnt = 0;
        for (int i = 0; i < 4; i++) send_byte(t4_codes[i]);
        check("t4_count_full", oCount, 4);
        check("t4_no_ovf", ovf_cnt, 0);
        send_byte(t4_codes[4]);
        check("t4_ovf", ovf_cnt, 1);
        check("t4_count_after", oCount, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_read%0d", i), oCode, t4_codes[i]);
            pop_one();
        end
        check("t4_empty", oCount, 0);

        // 5: truncated frame times out
        frm_cnt = 0;
        send_bits(mk(8'h5A, 1'b0, 1'b1), 4);
        wait_cyc(150);
        check("t5_no_early_err", frm_cnt, 0);
        wait_cyc(100);
        check("t5_timeout_err", frm_cnt, 1);
        send_byte(8'h29);
        check("t5_code", oCode, 8'h29);
        check("t5_count", oCount, 1);
        check("t5_err_total", frm_cnt, 1);
        pop_one();

        // 6: reset mid-frame with entries queued
        send_byte(8'h15);
        send_byte(8'h1D);
        check("t6_queued", oCount, 2);
        send_bits(mk(8'h24, 1'b0, 1'b1), 5);
        wait_cyc(5);
        Reset = 1'b0;
        wait_cyc(1);
        check("t6_rst_count", oCount, 0);
        check("t6_rst_outs", {oValid, oCode, oBreak, oExtended, oParityError, oFrameError, oOverflow}, 0);
        Reset = 1'b1;
        wait_cyc(20);
        send_byte(8'h5A);
        check("t6_count", oCount, 1);
        check("t6_code", oCode, 8'h5A);
        check("t6_flags", {oBreak, oExtended}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
